// File: rtl/id_ex_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage.
// ALU opcodes, control-bundle layout and widths.
package id_ex_operand_stage_pkg;

  localparam int DW_DEF  = 32;
  localparam int AW_DEF  = 5;
  localparam int IMM_W   = 16;
  localparam int SHAMT_W = 5;
  localparam int OP_W    = 4;
  localparam int CTRL_W  = 4;

  localparam logic [OP_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [OP_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [OP_W-1:0] ALU_NOR  = 4'b0010;
  localparam logic [OP_W-1:0] ALU_ADD  = 4'b0011;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'b0100;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'b0101;
  localparam logic [OP_W-1:0] ALU_WORD = 4'b0110;
  localparam logic [OP_W-1:0] ALU_LUI  = 4'b0111;
  localparam logic [OP_W-1:0] ALU_SLL  = 4'b1000;
  localparam logic [OP_W-1:0] ALU_SRL  = 4'b1001;

  localparam int CTRL_REG_WRITE  = 3;
  localparam int CTRL_MEM_READ   = 2;
  localparam int CTRL_MEM_WRITE  = 1;
  localparam int CTRL_MEM_TO_REG = 0;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_t;

  function automatic logic is_shift(input logic [OP_W-1:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL);
  endfunction

endpackage

// File: rtl/operand_forward_mux.sv
// Forwarding select for one EX source operand.
// EX/MEM beats MEM/WB; register 0 never forwards.
module operand_forward_mux #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] reg_data,
  input  logic          exmem_we,
  input  logic [AW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_data,
  input  logic          memwb_we,
  input  logic [AW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_data,
  output logic [DW-1:0] data
);

  logic hit_exmem;
  logic hit_memwb;

  assign hit_exmem = exmem_we & (exmem_rd != '0)
                   & (exmem_rd == addr);
  assign hit_memwb = memwb_we & (memwb_rd != '0)
                   & (memwb_rd == addr);

  // Youngest producer wins; fall back to the register file.
  always_comb begin
    data = reg_data;
    priority case (1'b1)
      hit_exmem: data = exmem_data;
      hit_memwb: data = memwb_data;
      default:   data = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX register feeding the ALU operands.
// Forwarding, shamt/immediate select and load-use detect.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = DW_DEF,
  parameter int REG_ADDR_WIDTH = AW_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [OP_W-1:0]           id_alu_op,
  input  logic [CTRL_W-1:0]         id_ctrl,
  input  logic                      id_alu_src,
  input  logic                      id_sign_ext,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
  input  logic [DATA_WIDTH-1:0]     id_rs_data,
  input  logic [DATA_WIDTH-1:0]     id_rt_data,
  input  logic [IMM_W-1:0]          id_imm,
  input  logic [SHAMT_W-1:0]        id_shamt,
  input  logic                      fwd_exmem_we,
  input  logic [REG_ADDR_WIDTH-1:0] fwd_exmem_rd,
  input  logic [DATA_WIDTH-1:0]     fwd_exmem_data,
  input  logic                      fwd_memwb_we,
  input  logic [REG_ADDR_WIDTH-1:0] fwd_memwb_rd,
  input  logic [DATA_WIDTH-1:0]     fwd_memwb_data,
  output logic                      load_use_hazard,
  output logic [OP_W-1:0]           alu_operation,
  output logic [DATA_WIDTH-1:0]     alu_a,
  output logic [DATA_WIDTH-1:0]     alu_b,
  output logic [DATA_WIDTH-1:0]     ex_store_data,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic [CTRL_W-1:0]         ex_ctrl,
  output logic                      ex_valid
);

  logic                      v_q;
  logic [OP_W-1:0]           op_q;
  ctrl_t                     ctrl_q;
  logic                      src_q;
  logic [REG_ADDR_WIDTH-1:0] rs_q;
  logic [REG_ADDR_WIDTH-1:0] rt_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0]     rsd_q;
  logic [DATA_WIDTH-1:0]     rtd_q;
  logic [DATA_WIDTH-1:0]     imm_q;
  logic [SHAMT_W-1:0]        shamt_q;

  logic [DATA_WIDTH-1:0]     imm_ext;
  logic [DATA_WIDTH-1:0]     rs_fwd;
  logic [DATA_WIDTH-1:0]     rt_fwd;
  logic                      bubble;

  // Extend once at load; LUI wants the raw half-word.
  always_comb begin
    imm_ext = {{(DATA_WIDTH-IMM_W){1'b0}}, id_imm};
    if (id_sign_ext && (id_alu_op != ALU_LUI))
      imm_ext = {{(DATA_WIDTH-IMM_W){id_imm[IMM_W-1]}},
                 id_imm};
  end

  // Loaded value in EX is not ready for the decode slot.
  always_comb begin
    load_use_hazard = v_q & ctrl_q.mem_read
                    & (rd_q != '0) & id_valid
                    & ((rd_q == id_rs_addr)
                      | (rd_q == id_rt_addr));
  end

  assign bubble = flush | load_use_hazard;

  // Stage register: hold on stall, clear on bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q     <= 1'b0;
      op_q    <= '0;
      ctrl_q  <= '0;
      src_q   <= 1'b0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      rsd_q   <= '0;
      rtd_q   <= '0;
      imm_q   <= '0;
      shamt_q <= '0;
    end else if (!stall) begin
      if (bubble) begin
        v_q     <= 1'b0;
        op_q    <= '0;
        ctrl_q  <= '0;
        src_q   <= 1'b0;
        rs_q    <= '0;
        rt_q    <= '0;
        rd_q    <= '0;
        rsd_q   <= '0;
        rtd_q   <= '0;
        imm_q   <= '0;
        shamt_q <= '0;
      end else begin
        v_q     <= id_valid;
        op_q    <= id_alu_op;
        ctrl_q  <= id_ctrl;
        src_q   <= id_alu_src;
        rs_q    <= id_rs_addr;
        rt_q    <= id_rt_addr;
        rd_q    <= id_rd_addr;
        rsd_q   <= id_rs_data;
        rtd_q   <= id_rt_data;
        imm_q   <= imm_ext;
        shamt_q <= id_shamt;
      end
    end
  end

  operand_forward_mux #(
    .DW (DATA_WIDTH),
    .AW (REG_ADDR_WIDTH)
  ) u_fwd_rs (
    .addr       (rs_q),
    .reg_data   (rsd_q),
    .exmem_we   (fwd_exmem_we),
    .exmem_rd   (fwd_exmem_rd),
    .exmem_data (fwd_exmem_data),
    .memwb_we   (fwd_memwb_we),
    .memwb_rd   (fwd_memwb_rd),
    .memwb_data (fwd_memwb_data),
    .data       (rs_fwd)
  );

  operand_forward_mux #(
    .DW (DATA_WIDTH),
    .AW (REG_ADDR_WIDTH)
  ) u_fwd_rt (
    .addr       (rt_q),
    .reg_data   (rtd_q),
    .exmem_we   (fwd_exmem_we),
    .exmem_rd   (fwd_exmem_rd),
    .exmem_data (fwd_exmem_data),
    .memwb_we   (fwd_memwb_we),
    .memwb_rd   (fwd_memwb_rd),
    .memwb_data (fwd_memwb_data),
    .data       (rt_fwd)
  );

  // Shifts take shamt on A; immediate forms take imm on B.
  always_comb begin
    alu_a = rs_fwd;
    alu_b = rt_fwd;
    if (is_shift(op_q))
      alu_a = {{(DATA_WIDTH-SHAMT_W){1'b0}}, shamt_q};
    if (src_q)
      alu_b = imm_q;
  end

  assign alu_operation = op_q;
  assign ex_store_data = rt_fwd;
  assign ex_rd         = rd_q;
  assign ex_ctrl       = ctrl_q;
  assign ex_valid      = v_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage.
// Directed scenarios then randomized traffic vs a model.
module tb_id_ex_operand_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic          flush;
  logic          id_valid;
  logic [3:0]    id_alu_op;
  logic [3:0]    id_ctrl;
  logic          id_alu_src;
  logic          id_sign_ext;
  logic [AW-1:0] id_rs_addr;
  logic [AW-1:0] id_rt_addr;
  logic [AW-1:0] id_rd_addr;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [15:0]   id_imm;
  logic [4:0]    id_shamt;
  logic          fwd_exmem_we;
  logic [AW-1:0] fwd_exmem_rd;
  logic [DW-1:0] fwd_exmem_data;
  logic          fwd_memwb_we;
  logic [AW-1:0] fwd_memwb_rd;
  logic [DW-1:0] fwd_memwb_data;
  logic          load_use_hazard;
  logic [3:0]    alu_operation;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] ex_store_data;
  logic [AW-1:0] ex_rd;
  logic [3:0]    ex_ctrl;
  logic          ex_valid;

  int checks = 0;
  int errors = 0;

  // Model of the instruction currently sitting in EX.
  logic          m_valid;
  logic [3:0]    m_op;
  logic [3:0]    m_ctrl;
  logic          m_src;
  logic          m_sext;
  logic [AW-1:0] m_rs;
  logic [AW-1:0] m_rt;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_rsd;
  logic [DW-1:0] m_rtd;
  logic [15:0]   m_imm;
  logic [4:0]    m_shamt;

  id_ex_operand_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .flush           (flush),
    .id_valid        (id_valid),
    .id_alu_op       (id_alu_op),
    .id_ctrl         (id_ctrl),
    .id_alu_src      (id_alu_src),
    .id_sign_ext     (id_sign_ext),
    .id_rs_addr      (id_rs_addr),
    .id_rt_addr      (id_rt_addr),
    .id_rd_addr      (id_rd_addr),
    .id_rs_data      (id_rs_data),
    .id_rt_data      (id_rt_data),
    .id_imm          (id_imm),
    .id_shamt        (id_shamt),
    .fwd_exmem_we    (fwd_exmem_we),
    .fwd_exmem_rd    (fwd_exmem_rd),
    .fwd_exmem_data  (fwd_exmem_data),
    .fwd_memwb_we    (fwd_memwb_we),
    .fwd_memwb_rd    (fwd_memwb_rd),
    .fwd_memwb_data  (fwd_memwb_data),
    .load_use_hazard (load_use_hazard),
    .alu_operation   (alu_operation),
    .alu_a           (alu_a),
    .alu_b           (alu_b),
    .ex_store_data   (ex_store_data),
    .ex_rd           (ex_rd),
    .ex_ctrl         (ex_ctrl),
    .ex_valid        (ex_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] m_fwd(
    input logic [AW-1:0] a, input logic [DW-1:0] rf);
    if (a == 0) return rf;
    if (fwd_exmem_we && fwd_exmem_rd == a)
      return fwd_exmem_data;
    if (fwd_memwb_we && fwd_memwb_rd == a)
      return fwd_memwb_data;
    return rf;
  endfunction

  function automatic logic exp_hz();
    return m_valid && m_ctrl[2] && m_rd != 0 && id_valid
      && (m_rd == id_rs_addr || m_rd == id_rt_addr);
  endfunction

  function automatic logic [DW-1:0] exp_a();
    if (m_op == 4'd8 || m_op == 4'd9) return DW'(m_shamt);
    return m_fwd(m_rs, m_rsd);
  endfunction

  function automatic logic [DW-1:0] exp_b();
    int s;
    if (!m_src) return m_fwd(m_rt, m_rtd);
    if (m_sext && m_op != 4'd7) begin
      s = $signed(m_imm);
      return DW'(s);
    end
    return DW'(m_imm);
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".hz"}, DW'(load_use_hazard), DW'(exp_hz()));
    chk({tag, ".op"}, DW'(alu_operation), DW'(m_op));
    chk({tag, ".a"}, alu_a, exp_a());
    chk({tag, ".b"}, alu_b, exp_b());
    chk({tag, ".st"}, ex_store_data, m_fwd(m_rt, m_rtd));
    chk({tag, ".rd"}, DW'(ex_rd), DW'(m_rd));
    chk({tag, ".ctrl"}, DW'(ex_ctrl), DW'(m_ctrl));
    chk({tag, ".v"}, DW'(ex_valid), DW'(m_valid));
  endtask

  task automatic m_clear();
    m_valid = 0; m_op = 0; m_ctrl = 0; m_src = 0;
    m_sext = 0; m_rs = 0; m_rt = 0; m_rd = 0;
    m_rsd = 0; m_rtd = 0; m_imm = 0; m_shamt = 0;
  endtask

  // Advance model and DUT by one edge, then compare.
  task automatic tick(input string tag);
    logic hz;
    hz = exp_hz();
    if (!stall) begin
      if (flush || hz) m_clear();
      else begin
        m_valid = id_valid; m_op = id_alu_op;
        m_ctrl = id_ctrl; m_src = id_alu_src;
        m_sext = id_sign_ext; m_rs = id_rs_addr;
        m_rt = id_rt_addr; m_rd = id_rd_addr;
        m_rsd = id_rs_data; m_rtd = id_rt_data;
        m_imm = id_imm; m_shamt = id_shamt;
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_id(
    input logic v, input logic [3:0] op,
    input logic [3:0] c, input logic src,
    input logic sx, input logic [AW-1:0] rs,
    input logic [AW-1:0] rt, input logic [AW-1:0] rd,
    input logic [DW-1:0] rsd, input logic [DW-1:0] rtd,
    input logic [15:0] imm, input logic [4:0] sh);
    id_valid = v; id_alu_op = op; id_ctrl = c;
    id_alu_src = src; id_sign_ext = sx;
    id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
    id_rs_data = rsd; id_rt_data = rtd;
    id_imm = imm; id_shamt = sh;
  endtask

  task automatic set_fwd(
    input logic ew, input logic [AW-1:0] er,
    input logic [DW-1:0] ed, input logic mw,
    input logic [AW-1:0] mr, input logic [DW-1:0] md);
    fwd_exmem_we = ew; fwd_exmem_rd = er;
    fwd_exmem_data = ed; fwd_memwb_we = mw;
    fwd_memwb_rd = mr; fwd_memwb_data = md;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    m_clear();
    #2;
    check_all("reset");
    #10;
    reset = 1'b1;

    // Reset in the middle of a cycle with a live instruction.
    set_id(1, 4'd3, 4'b1000, 0, 0, 5'd3, 5'd4, 5'd7,
           32'h1111_2222, 32'h3333_4444, 16'h0, 5'd0);
    tick("t1_load");
    chk("t1_valid", DW'(ex_valid), 1);
    #2;
    reset = 1'b0;
    m_clear();
    #1;
    check_all("t1_async");
    chk("t1_a0", alu_a, 0);
    #2;
    reset = 1'b1;

    // EX/MEM beats MEM/WB; then MEM/WB alone.
    set_id(1, 4'd3, 4'b1000, 0, 0, 5'd5, 5'd2, 5'd9,
           32'h5555_5555, 32'h2, 16'h0, 5'd0);
    set_fwd(1, 5'd5, 32'hAAAA_0000, 1, 5'd5, 32'h1);
    tick("t2_load");
    chk("t2_exmem", alu_a, 32'hAAAA_0000);
    fwd_exmem_rd = 5'd6;
    #1;
    chk("t2_memwb", alu_a, 32'h1);
    check_all("t2_all");

    // Register zero is never forwarded.
    set_id(1, 4'd3, 4'b1000, 0, 0, 5'd0, 5'd0, 5'd1,
           32'h0, 32'h0, 16'h0, 5'd0);
    set_fwd(1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 32'hFFFF_FFFF);
    tick("t3");
    chk("t3_r0", alu_a, 0);

    // Load-use: LW r8 in EX, consumer reads rt=8.
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 4'd3, 4'b1100, 1, 1, 5'd2, 5'd9, 5'd8,
           32'h100, 32'h0, 16'h0010, 5'd0);
    tick("t4_lw");
    set_id(1, 4'd3, 4'b1000, 0, 0, 5'd1, 5'd8, 5'd10,
           32'd11, 32'd22, 16'h0, 5'd0);
    #1;
    chk("t4_hz", DW'(load_use_hazard), 1);
    tick("t4_bubble");
    chk("t4_v0", DW'(ex_valid), 0);
    chk("t4_c0", DW'(ex_ctrl), 0);
    chk("t4_hz0", DW'(load_use_hazard), 0);
    set_fwd(0, 0, 0, 1, 5'd8, 32'h1234_5678);
    tick("t4_reload");
    chk("t4_b_wb", alu_b, 32'h1234_5678);

    // Shift amount and sign-extended immediate.
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 4'd8, 4'b1000, 0, 0, 5'd0, 5'd3, 5'd4,
           32'hDEAD_BEEF, 32'h3, 16'h0, 5'd4);
    tick("t5_sll");
    chk("t5_a", alu_a, 32'd4);
    chk("t5_b", alu_b, 32'd3);
    chk("t5_op", DW'(alu_operation), 32'b1000);
    set_id(1, 4'd3, 4'b1000, 1, 1, 5'd1, 5'd2, 5'd2,
           32'h7, 32'h9, 16'hFFFF, 5'd0);
    tick("t5_addi");
    chk("t5_imm", alu_b, 32'hFFFF_FFFF);
    set_id(1, 4'd7, 4'b1000, 1, 1, 5'd0, 5'd0, 5'd2,
           32'h0, 32'h0, 16'h8001, 5'd0);
    tick("t5_lui");
    chk("t5_lui", alu_b, 32'h0000_8001);

    // Stall over flush, flush alone, then release.
    set_id(1, 4'd1, 4'b1000, 0, 0, 5'd3, 5'd4, 5'd12,
           32'h10, 32'h20, 16'h0, 5'd0);
    tick("t6_pre");
    stall = 1'b1; flush = 1'b1;
    set_id(1, 4'd4, 4'b1001, 0, 0, 5'd6, 5'd7, 5'd13,
           32'h30, 32'h40, 16'h0, 5'd0);
    tick("t6_hold");
    chk("t6_hold_rd", DW'(ex_rd), 12);
    stall = 1'b0;
    tick("t6_flush");
    chk("t6_flush_v", DW'(ex_valid), 0);
    flush = 1'b0;
    tick("t6_load");
    chk("t6_load_rd", DW'(ex_rd), 13);

    // Randomized traffic on a small register window.
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(7) == 0);
      flush = ($urandom_range(9) == 0);
      set_id($urandom_range(4) != 0,
             4'($urandom_range(9)), 4'($urandom),
             1'($urandom), 1'($urandom),
             AW'($urandom_range(5)), AW'($urandom_range(5)),
             AW'($urandom_range(5)), $urandom, $urandom,
             16'($urandom), 5'($urandom));
      set_fwd(1'($urandom), AW'($urandom_range(5)), $urandom,
              1'($urandom), AW'($urandom_range(5)), $urandom);
      #1;
      check_all("rnd_pre");
      tick("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
